// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with pixel fetch, underflow flag and DAC-aligned sync/colour; optional TEST_PATTERN_EN colour bars.
// Latency: pix_req_o to DAC outputs (sync, active video, rgb) is 2 clk_i cycles, all outputs mutually aligned.
// Backpressure: none; the pixel source must answer 1 cycle after each request or the pixel is blanked and underflow_o set.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_underflow_i,
`ifdef TEST_PATTERN_EN
  input  logic          pattern_sel_i,
`endif
  output logic          pix_req_o,
  output logic [HW-1:0] pix_x_o,
  output logic [VW-1:0] pix_y_o,
  input  logic          pix_valid_i,
  input  logic [11:0]   pix_rgb_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          active_video_o,
  output logic [3:0]    r_o,
  output logic [3:0]    g_o,
  output logic [3:0]    b_o,
  output logic          frame_start_o,
  output logic          underflow_o
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            run;
  logic            h_last, v_last;
  logic            in_active;

  // stage-1 registers (counter snapshot one cycle behind)
  logic            run_d1, act_d1, req_d1;
  logic [HW-1:0]   h_d1;
  logic [VW-1:0]   v_d1;
  logic [11:0]     pix_s1;
  logic            uf_set;
  logic            hs_on, vs_on;
  logic [11:0]     rgb_q;

  assign run    = (state_q == RUN);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Run/stop decisions only happen at the last pixel of a frame so frames are never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (h_last && v_last && !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Raster counters: held at origin while idle, free-running with wrap while running.
  always_ff @(posedge clk_i) begin
    if (rst_i || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0: fetch request straight from the counters.
  assign in_active     = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pix_x_o       = h_cnt;
  assign pix_y_o       = v_cnt;
  assign frame_start_o = run && (h_cnt == '0) && (v_cnt == '0);
`ifdef TEST_PATTERN_EN
  assign pix_req_o     = in_active && !pattern_sel_i;
`else
  assign pix_req_o     = in_active;
`endif

`ifdef TEST_PATTERN_EN
  localparam logic [HW-1:0] HBAR = HW'(H_ACTIVE / 8);
  logic        pat_d1;
  logic [2:0]  bar_idx;
  logic [11:0] bar_rgb;

  assign bar_idx = 3'(h_d1 / HBAR);

  // Colour-bar lookup, left to right
  always_comb begin
    bar_rgb = 12'h000;
    case (bar_idx)
      3'd0: bar_rgb = 12'hFFF;
      3'd1: bar_rgb = 12'hFF0;
      3'd2: bar_rgb = 12'h0FF;
      3'd3: bar_rgb = 12'h0F0;
      3'd4: bar_rgb = 12'hF0F;
      3'd5: bar_rgb = 12'hF00;
      3'd6: bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  // Pattern select travels with its pixel so a mid-line switch stays aligned
  always_ff @(posedge clk_i) begin
    if (rst_i) pat_d1 <= 1'b0;
    else       pat_d1 <= pattern_sel_i;
  end
`endif

  // Stage 1 capture: snapshot of the counter position the returning pixel belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_d1 <= 1'b0;
      act_d1 <= 1'b0;
      req_d1 <= 1'b0;
      h_d1   <= '0;
      v_d1   <= '0;
    end else begin
      run_d1 <= run;
      act_d1 <= in_active;
      req_d1 <= pix_req_o;
      h_d1   <= h_cnt;
      v_d1   <= v_cnt;
    end
  end

  // Stage 1 check: a requested pixel without valid is blanked and flagged; unsolicited valids are ignored.
  always_comb begin
    pix_s1 = 12'h000;
    uf_set = 1'b0;
    if (req_d1) begin
      if (pix_valid_i) pix_s1 = pix_rgb_i;
      else             uf_set = 1'b1;
    end
`ifdef TEST_PATTERN_EN
    if (pat_d1 && act_d1) pix_s1 = bar_rgb;
`endif
  end

  assign hs_on = run_d1 && (h_d1 >= HS_FIRST) && (h_d1 <= HS_LAST);
  assign vs_on = run_d1 && (v_d1 >= VS_FIRST) && (v_d1 <= VS_LAST);

  // Stage 2: register every DAC-facing signal on the same edge so they stay phase-matched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_o        <= ~SYNC_POL;
      vsync_o        <= ~SYNC_POL;
      active_video_o <= 1'b0;
      rgb_q          <= 12'h000;
    end else begin
      hsync_o        <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync_o        <= vs_on ? SYNC_POL : ~SYNC_POL;
      active_video_o <= act_d1;
      rgb_q          <= act_d1 ? pix_s1 : 12'h000;
    end
  end

  assign r_o = rgb_q[11:8];
  assign g_o = rgb_q[7:4];
  assign b_o = rgb_q[3:0];

  // Sticky underflow flag; a new underflow outranks a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)                underflow_o <= 1'b0;
    else if (uf_set)          underflow_o <= 1'b1;
    else if (clr_underflow_i) underflow_o <= 1'b0;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a shrunken raster (24x10 total, 16x6 visible).
// Pixel source answers one cycle after each request with rgb = column, with one-shot drop injection.
// Expected values come from hand-derived raster arithmetic for these small timings.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB; // 24
  localparam int VT = VA + VF + VS + VB; // 10

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        clr_underflow_i = 1'b0;
  logic        pattern_sel_i = 1'b0;
  logic        pix_req_o;
  logic [4:0]  pix_x_o;
  logic [3:0]  pix_y_o;
  logic        pix_valid_i = 1'b0;
  logic [11:0] pix_rgb_i = 12'h000;
  logic        hsync_o, vsync_o, active_video_o;
  logic [3:0]  r_o, g_o, b_o;
  logic        frame_start_o, underflow_o;

  int total = 0;
  int bad = 0;

  logic        drop_arm = 1'b0;
  int          drop_x = 5;
  int          drop_y = 3;
  logic        valid_next = 1'b0;
  logic [11:0] rgb_next = 12'h000;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .clr_underflow_i(clr_underflow_i),
`ifdef TEST_PATTERN_EN
    .pattern_sel_i(pattern_sel_i),
`endif
    .pix_req_o(pix_req_o),
    .pix_x_o(pix_x_o),
    .pix_y_o(pix_y_o),
    .pix_valid_i(pix_valid_i),
    .pix_rgb_i(pix_rgb_i),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .active_video_o(active_video_o),
    .r_o(r_o),
    .g_o(g_o),
    .b_o(b_o),
    .frame_start_o(frame_start_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Pixel source: sees the request mid-cycle, answers during the following cycle.
  always @(negedge clk_i) begin
    valid_next = pix_req_o && !(drop_arm && int'(pix_x_o) == drop_x && int'(pix_y_o) == drop_y);
    rgb_next   = 12'(pix_x_o);
  end

  always @(posedge clk_i) begin
    #1;
    pix_valid_i = valid_next;
    pix_rgb_i   = rgb_next;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_xy(input int x, input int y, input string tag);
    int n;
    n = 0;
    while (!(int'(pix_x_o) == x && int'(pix_y_o) == y) && n < 600) begin
      step(1);
      n++;
    end
    check(tag, {pix_y_o, pix_x_o}, {4'(y), 5'(x)});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, 32'(hsync_o), 32'd1);
    check({tag, "_vsync"}, 32'(vsync_o), 32'd1);
    check({tag, "_active"}, 32'(active_video_o), 32'd0);
    check({tag, "_rgb"}, 32'({r_o, g_o, b_o}), 32'd0);
    check({tag, "_req"}, 32'(pix_req_o), 32'd0);
    check({tag, "_xy"}, 32'({pix_y_o, pix_x_o}), 32'd0);
    check({tag, "_fs"}, 32'(frame_start_o), 32'd0);
    check({tag, "_uf"}, 32'(underflow_o), 32'd0);
  endtask

  initial begin
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Reset state
    step(2);
    check_reset_vals("reset");
    rst_i = 1'b0;
    step(3);
    check("idle_fs", 32'(frame_start_o), 32'd0);
    check("idle_req", 32'(pix_req_o), 32'd0);

    // Start: first frame runs with a single dropped pixel at (5,3)
    drop_x = 5; drop_y = 3; drop_arm = 1'b1;
    en_i = 1'b1;
    step(1);
    for (int k = 0; k < 242; k++) begin
      int hx0, vy0, kk, hx, vy;
      logic e_req, e_act, e_hs, e_vs, e_fs, e_uf;
      logic [11:0] e_rgb;
      hx0   = k % HT;
      vy0   = (k / HT) % VT;
      e_req = (hx0 < HA) && (vy0 < VA);
      e_fs  = (hx0 == 0) && (vy0 == 0);
      kk    = k - 2;
      hx    = (kk >= 0) ? kk % HT : 0;
      vy    = (kk >= 0) ? (kk / HT) % VT : 0;
      e_act = (kk >= 0) && (hx < HA) && (vy < VA);
      e_hs  = (kk >= 0) && (hx >= 18) && (hx <= 20);
      e_vs  = (kk >= 0) && (vy >= 7) && (vy <= 8);
      e_rgb = (e_act && !(kk < HT * VT && hx == 5 && vy == 3)) ? 12'(hx) : 12'h000;
      e_uf  = (k >= 79);
      check("run_req", 32'(pix_req_o), 32'(e_req));
      check("run_fs", 32'(frame_start_o), 32'(e_fs));
      check("run_active", 32'(active_video_o), 32'(e_act));
      check("run_rgb", 32'({r_o, g_o, b_o}), 32'(e_rgb));
      check("run_hsync", 32'(hsync_o), 32'(!e_hs));
      check("run_vsync", 32'(vsync_o), 32'(!e_vs));
      check("run_uf", 32'(underflow_o), 32'(e_uf));
      step(1);
    end
    drop_arm = 1'b0;

    // Clear alone drops the sticky flag
    clr_underflow_i = 1'b1;
    step(1);
    clr_underflow_i = 1'b0;
    check("clr_alone", 32'(underflow_o), 32'd0);

    // New underflow at (2,1) with a clear in the same cycle: set wins
    drop_x = 2; drop_y = 1; drop_arm = 1'b1;
    wait_xy(2, 1, "wait_drop");
    step(1);
    drop_arm = 1'b0;
    clr_underflow_i = 1'b1;
    step(1);
    clr_underflow_i = 1'b0;
    check("set_wins_uf", 32'(underflow_o), 32'd1);
    check("drop_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    check("drop_active", 32'(active_video_o), 32'd1);
    clr_underflow_i = 1'b1;
    step(1);
    clr_underflow_i = 1'b0;
    check("next_rgb", 32'({r_o, g_o, b_o}), 32'h003);
    check("clr_after", 32'(underflow_o), 32'd0);

    // Drop en_i mid-frame: frame completes, then idle
    wait_xy(0, 4, "wait_line4");
    en_i = 1'b0;
    wait_xy(HT - 1, VT - 1, "frame_complete");
    step(1);
    check("stop_fs", 32'(frame_start_o), 32'd0);
    check("stop_req", 32'(pix_req_o), 32'd0);
    check("stop_xy", 32'({pix_y_o, pix_x_o}), 32'd0);
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("idle_hold_fs", 32'(frame_start_o), 32'd0);
      check("idle_hold_hs", 32'(hsync_o), 32'd1);
      check("idle_hold_vs", 32'(vsync_o), 32'd1);
      check("idle_hold_act", 32'(active_video_o), 32'd0);
    end
    en_i = 1'b1;
    step(1);
    check("restart_fs", 32'(frame_start_o), 32'd1);
    check("restart_xy", 32'({pix_y_o, pix_x_o}), 32'd0);

    // Mid-frame reset with a pixel in flight
    wait_xy(5, 2, "wait_rst_pt");
    check("pre_rst_active", 32'(active_video_o), 32'd1);
    check("pre_rst_rgb", 32'({r_o, g_o, b_o}), 32'h003);
    rst_i = 1'b1;
    step(1);
    check_reset_vals("midrst");
    rst_i = 1'b0;
    step(1);
    check("post_rst_fs", 32'(frame_start_o), 32'd1);
    check("post_rst_xy", 32'({pix_y_o, pix_x_o}), 32'd0);
    step(2);
    check("post_rst_active", 32'(active_video_o), 32'd1);
    check("post_rst_rgb", 32'({r_o, g_o, b_o}), 32'd0);

`ifdef TEST_PATTERN_EN
    // Colour bars: two columns per bar with this raster
    pattern_sel_i = 1'b1;
    wait_xy(0, 1, "wait_pattern");
    check("pat_req", 32'(pix_req_o), 32'd0);
    step(2);
    for (int k = 0; k < HA; k++) begin
      check("pat_rgb", 32'({r_o, g_o, b_o}), 32'(bars[k / (HA / 8)]));
      check("pat_active", 32'(active_video_o), 32'd1);
      step(1);
    end
    check("pat_uf", 32'(underflow_o), 32'd0);
    pattern_sel_i = 1'b0;
`else
    check("bars_unused", 32'(bars[0]), 32'hFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
